// File: rtl/muldiv_pkg.sv
// muldiv_pkg
// Shared definitions for the HI/LO multiply/divide unit: the 4-bit op
// encoding issued from EX, the sequencing FSM states, and the datapath
// width and divider iteration count.
package muldiv_pkg;

  localparam int DATA_W   = 32;
  localparam int DIV_ITER = 32;

  // Op codes driven on i_op; any code not listed is a NOP.
  typedef enum logic [3:0] {
    OP_MULT  = 4'd0,
    OP_MULTU = 4'd1,
    OP_DIV   = 4'd2,
    OP_DIVU  = 4'd3,
    OP_MTHI  = 4'd4,
    OP_MTLO  = 4'd5,
    OP_MADD  = 4'd6,
    OP_MADDU = 4'd7,
    OP_MSUB  = 4'd8,
    OP_MSUBU = 4'd9
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_WB   = 2'd3
  } state_e;

endpackage

// File: rtl/muldiv_ctrl_div_core.sv
// div_core
// Radix-2 restoring unsigned divider, one quotient bit per cycle.
// The first iteration is performed on the start edge directly from the
// operands, so DIV_ITER iterations occupy the start edge plus DIV_ITER-1
// further edges.
// Ports:
//   i_clk, i_rst   clock, synchronous active-high reset
//   i_start        load operands and perform the first iteration
//   i_a, i_b       dividend, divisor (unsigned)
//   o_done         high in the cycle whose closing edge performs the final
//                  iteration; o_quotient/o_remainder are final from the
//                  following cycle
//   o_quotient     quotient (all ones on divide by zero)
//   o_remainder    remainder (equals i_a on divide by zero)
module div_core
  import muldiv_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  output logic              o_done,
  output logic [DATA_W-1:0] o_quotient,
  output logic [DATA_W-1:0] o_remainder
);

  logic [63:0]       r_rem;
  logic [63:0]       r_div;
  logic [DATA_W-1:0] r_quo;
  logic [5:0]        r_cnt;
  logic              r_active;

  logic [63:0]       w_rem_src;
  logic [63:0]       w_div_src;
  logic [DATA_W-1:0] w_quo_src;
  logic              w_fits;
  logic [63:0]       w_rem_nxt;
  logic [63:0]       w_div_nxt;
  logic [DATA_W-1:0] w_quo_nxt;

  // One restoring step. On start the step works on the fresh operands with
  // the divisor pre-shifted to align its LSB with quotient bit 31; a zero
  // divisor always "fits", which yields the all-ones quotient and leaves
  // the dividend untouched as the remainder.
  always_comb begin
    w_rem_src = i_start ? {32'd0, i_a} : r_rem;
    w_div_src = i_start ? {1'b0, i_b, 31'd0} : r_div;
    w_quo_src = i_start ? '0 : r_quo;
    w_fits    = (w_rem_src >= w_div_src);
    w_rem_nxt = w_fits ? (w_rem_src - w_div_src) : w_rem_src;
    w_div_nxt = w_div_src >> 1;
    w_quo_nxt = {w_quo_src[DATA_W-2:0], w_fits};
  end

  // Iteration registers; r_cnt counts completed iterations.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rem    <= '0;
      r_div    <= '0;
      r_quo    <= '0;
      r_cnt    <= '0;
      r_active <= 1'b0;
    end else if (i_start) begin
      r_rem    <= w_rem_nxt;
      r_div    <= w_div_nxt;
      r_quo    <= w_quo_nxt;
      r_cnt    <= 6'd1;
      r_active <= 1'b1;
    end else if (r_active) begin
      r_rem <= w_rem_nxt;
      r_div <= w_div_nxt;
      r_quo <= w_quo_nxt;
      r_cnt <= r_cnt + 6'd1;
      if (r_cnt == 6'(DIV_ITER - 1)) begin
        r_active <= 1'b0;
      end
    end
  end

  assign o_done      = r_active && (r_cnt == 6'(DIV_ITER - 1));
  assign o_quotient  = r_quo;
  assign o_remainder = r_rem[DATA_W-1:0];

endmodule

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl
// Owns architectural HI/LO and sequences MIPS mul/div ops from EX.
// Multiply result is computed at acceptance and written after MUL_LAT
// edges; divide runs in div_core with sign fix-up done here.
// Optional macro MULDIV_MADD_EN enables MADD/MADDU/MSUB/MSUBU (ops 6..9);
// without it those codes are NOPs.
// Ports:
//   i_clk, i_rst     clock, synchronous active-high reset
//   i_op_valid       mul/div/MT op in EX
//   i_op             op code (see muldiv_pkg::op_e)
//   i_flush          EX op is squashed this cycle
//   i_src_a, i_src_b rs, rt values
//   i_mf_req         MFHI/MFLO in EX
//   i_mf_sel         0 = HI, 1 = LO
//   o_mf_data        selected HI/LO (combinational)
//   o_stall          hold IF/ID/EX
//   o_busy           mul or div in flight
//   o_hi, o_lo       architectural HI/LO
module muldiv_ctrl
  import muldiv_pkg::*;
#(
  parameter int MUL_LAT = 2
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_op_valid,
  input  logic [3:0]        i_op,
  input  logic              i_flush,
  input  logic [DATA_W-1:0] i_src_a,
  input  logic [DATA_W-1:0] i_src_b,
  input  logic              i_mf_req,
  input  logic              i_mf_sel,
  output logic [DATA_W-1:0] o_mf_data,
  output logic              o_stall,
  output logic              o_busy,
  output logic [DATA_W-1:0] o_hi,
  output logic [DATA_W-1:0] o_lo
);

  state_e            r_state;
  state_e            w_state_nxt;
  logic [3:0]        r_cnt;
  logic [3:0]        w_cnt_nxt;
  logic [DATA_W-1:0] r_hi;
  logic [DATA_W-1:0] r_lo;
  logic [63:0]       r_prod;
  logic [3:0]        r_op;
  logic              r_q_neg;
  logic              r_r_neg;
  logic              r_dz;
  logic [DATA_W-1:0] r_src_a;

  logic              w_accept;
  logic              w_is_mul;
  logic              w_is_div;
  logic              w_signed;
  logic [63:0]       w_ext_a;
  logic [63:0]       w_ext_b;
  logic [63:0]       w_prod;
  logic [DATA_W-1:0] w_a_mag;
  logic [DATA_W-1:0] w_b_mag;
  logic              w_div_done;
  logic [DATA_W-1:0] w_div_quo;
  logic [DATA_W-1:0] w_div_rem;
  logic [DATA_W-1:0] w_quo_fix;
  logic [DATA_W-1:0] w_rem_fix;
  logic [63:0]       w_wb_val;

  assign w_accept = (r_state == S_IDLE) && i_op_valid && !i_flush;

  // Op classification. Accumulating multiplies only exist when the
  // feature is built in; otherwise they fall through as NOPs.
  always_comb begin
    w_is_mul = 1'b0;
    w_is_div = 1'b0;
    w_signed = 1'b0;
    case (i_op)
      OP_MULT:  begin w_is_mul = 1'b1; w_signed = 1'b1; end
      OP_MULTU: w_is_mul = 1'b1;
      OP_DIV:   begin w_is_div = 1'b1; w_signed = 1'b1; end
      OP_DIVU:  w_is_div = 1'b1;
`ifdef MULDIV_MADD_EN
      OP_MADD:  begin w_is_mul = 1'b1; w_signed = 1'b1; end
      OP_MADDU: w_is_mul = 1'b1;
      OP_MSUB:  begin w_is_mul = 1'b1; w_signed = 1'b1; end
      OP_MSUBU: w_is_mul = 1'b1;
`else
      OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: w_is_mul = 1'b0;
`endif
      default:  w_is_mul = 1'b0;
    endcase
  end

  // A single 64x64 multiply of sign- or zero-extended operands gives the
  // correct low 64 bits for both signednesses.
  assign w_ext_a = {{32{w_signed & i_src_a[31]}}, i_src_a};
  assign w_ext_b = {{32{w_signed & i_src_b[31]}}, i_src_b};
  assign w_prod  = w_ext_a * w_ext_b;

  assign w_a_mag = (w_signed && i_src_a[31]) ? -i_src_a : i_src_a;
  assign w_b_mag = (w_signed && i_src_b[31]) ? -i_src_b : i_src_b;

  div_core u_div (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_start     (w_accept && w_is_div),
    .i_a         (w_a_mag),
    .i_b         (w_b_mag),
    .o_done      (w_div_done),
    .o_quotient  (w_div_quo),
    .o_remainder (w_div_rem)
  );

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next-state logic. MUL leaves when the counter steps to zero, so the
  // total non-idle time for a multiply is MUL_LAT cycles including WB.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_accept && w_is_mul) begin
          w_cnt_nxt   = 4'(MUL_LAT - 1);
          w_state_nxt = (MUL_LAT == 1) ? S_WB : S_MUL;
        end else if (w_accept && w_is_div) begin
          w_state_nxt = S_DIV;
        end
      end
      S_MUL: begin
        w_cnt_nxt = r_cnt - 4'd1;
        if (r_cnt == 4'd1) begin
          w_state_nxt = S_WB;
        end
      end
      S_DIV: begin
        if (w_div_done) begin
          w_state_nxt = S_WB;
        end
      end
      S_WB:    w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Operand context captured at acceptance for use at WB.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_op    <= '0;
      r_prod  <= '0;
      r_q_neg <= 1'b0;
      r_r_neg <= 1'b0;
      r_dz    <= 1'b0;
      r_src_a <= '0;
    end else if (w_accept) begin
      r_op    <= i_op;
      r_prod  <= w_prod;
      r_q_neg <= w_signed & (i_src_a[31] ^ i_src_b[31]);
      r_r_neg <= w_signed & i_src_a[31];
      r_dz    <= (i_src_b == '0);
      r_src_a <= i_src_a;
    end
  end

  // WB value. Divide by zero bypasses the sign fix-up so HI carries the
  // raw rs value for both signednesses.
  always_comb begin
    w_quo_fix = r_q_neg ? -w_div_quo : w_div_quo;
    w_rem_fix = r_r_neg ? -w_div_rem : w_div_rem;
    w_wb_val  = r_prod;
    case (r_op)
      OP_DIV, OP_DIVU:
        w_wb_val = r_dz ? {r_src_a, 32'hFFFF_FFFF} : {w_rem_fix, w_quo_fix};
`ifdef MULDIV_MADD_EN
      OP_MADD, OP_MADDU: w_wb_val = {r_hi, r_lo} + r_prod;
      OP_MSUB, OP_MSUBU: w_wb_val = {r_hi, r_lo} - r_prod;
`endif
      default: w_wb_val = r_prod;
    endcase
  end

  // HI/LO: MT writes land at acceptance, mul/div results at WB.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (r_state == S_WB) begin
      r_hi <= w_wb_val[63:32];
      r_lo <= w_wb_val[31:0];
    end else if (w_accept && (i_op == OP_MTHI)) begin
      r_hi <= i_src_a;
    end else if (w_accept && (i_op == OP_MTLO)) begin
      r_lo <= i_src_a;
    end
  end

  assign o_busy    = (r_state != S_IDLE);
  assign o_stall   = o_busy && (i_op_valid || i_mf_req) && !i_flush;
  assign o_mf_data = i_mf_sel ? r_lo : r_hi;
  assign o_hi      = r_hi;
  assign o_lo      = r_lo;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb_muldiv_ctrl
// Directed bench for muldiv_ctrl: reset, MULT/MULTU latency, signed DIV
// with MFHI stall length, divide corner cases, MT/MF, flush, reset during
// a divide, simultaneous op+MF, and the MADD feature (MULDIV_MADD_EN).
module tb_muldiv_ctrl;

  localparam int MUL_LAT = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        op_valid;
  logic [3:0]  op;
  logic        flush;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        mf_req;
  logic        mf_sel;
  logic [31:0] mf_data;
  logic        stall;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks = 0;
  int errors = 0;

  muldiv_ctrl #(.MUL_LAT(MUL_LAT)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_op_valid (op_valid),
    .i_op       (op),
    .i_flush    (flush),
    .i_src_a    (src_a),
    .i_src_b    (src_b),
    .i_mf_req   (mf_req),
    .i_mf_sel   (mf_sel),
    .o_mf_data  (mf_data),
    .o_stall    (stall),
    .o_busy     (busy),
    .o_hi       (hi),
    .o_lo       (lo)
  );

  // 10 ns clock.
  always #5 clk = ~clk;

  // Single comparison point for every check in the bench.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic valid, input logic [3:0] opc,
                               input logic [31:0] a, input logic [31:0] b);
    op_valid = valid;
    op       = opc;
    src_a    = a;
    src_b    = b;
  endtask

  // Advance n clock edges, landing 1 ns after the last one.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Present an op for one cycle; the accepting cycle must not stall.
  task automatic issueOp(input logic [3:0] opc, input logic [31:0] a,
                         input logic [31:0] b);
    applyStimulus(1'b1, opc, a, b);
    #1;
    checkOutput("accept_no_stall", {31'd0, stall}, 32'd0);
    tick(1);
    applyStimulus(1'b0, 4'd0, 32'd0, 32'd0);
  endtask

  task automatic waitIdle(input int bound);
    for (int i = 0; i < bound; i++) begin
      if (!busy) break;
      tick(1);
    end
    checkOutput("idle_timeout", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int stallCnt;

    rst    = 1'b1;
    flush  = 1'b0;
    mf_req = 1'b0;
    mf_sel = 1'b0;
    applyStimulus(1'b0, 4'd0, 32'd0, 32'd0);
    tick(3);
    checkOutput("reset_hi", hi, 32'd0);
    checkOutput("reset_lo", lo, 32'd0);
    checkOutput("reset_busy", {31'd0, busy}, 32'd0);
    checkOutput("reset_stall", {31'd0, stall}, 32'd0);
    rst = 1'b0;
    tick(1);

    // MULT -2 * 3 = -6: result appears exactly MUL_LAT edges after acceptance.
    issueOp(4'd0, 32'hFFFF_FFFE, 32'd3);
    for (int k = 0; k < MUL_LAT; k++) begin
      checkOutput("mult_early_lo", lo, 32'd0);
      checkOutput("mult_busy", {31'd0, busy}, 32'd1);
      tick(1);
    end
    checkOutput("mult_hi", hi, 32'hFFFF_FFFF);
    checkOutput("mult_lo", lo, 32'hFFFF_FFFA);
    checkOutput("mult_done_busy", {31'd0, busy}, 32'd0);

    // MULTU 0xFFFFFFFE * 3 = 0x2_FFFFFFFA.
    issueOp(4'd1, 32'hFFFF_FFFE, 32'd3);
    for (int k = 0; k < MUL_LAT; k++) begin
      checkOutput("multu_early_hi", hi, 32'hFFFF_FFFF);
      tick(1);
    end
    checkOutput("multu_hi", hi, 32'h0000_0002);
    checkOutput("multu_lo", lo, 32'hFFFF_FFFA);

    // DIV -7/2 with MFHI issued the next cycle: stalled for 32 cycles.
    issueOp(4'd2, 32'hFFFF_FFF9, 32'd2);
    mf_req = 1'b1;
    mf_sel = 1'b0;
    #1;
    stallCnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (!stall) break;
      stallCnt++;
      tick(1);
    end
    checkOutput("div_stall_cycles", stallCnt, 32'd32);
    checkOutput("div_mfhi", mf_data, 32'hFFFF_FFFF);
    checkOutput("div_lo", lo, 32'hFFFF_FFFD);
    checkOutput("div_hi", hi, 32'hFFFF_FFFF);
    mf_req = 1'b0;

    // DIVU 100/0.
    issueOp(4'd3, 32'd100, 32'd0);
    waitIdle(40);
    checkOutput("divu_dz_lo", lo, 32'hFFFF_FFFF);
    checkOutput("divu_dz_hi", hi, 32'd100);

    // DIV overflow 0x80000000 / -1.
    issueOp(4'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    waitIdle(40);
    checkOutput("div_ovf_lo", lo, 32'h8000_0000);
    checkOutput("div_ovf_hi", hi, 32'd0);

    // MTLO then immediate MFLO; MTHI.
    issueOp(4'd5, 32'h0000_1234, 32'd0);
    checkOutput("mtlo_busy", {31'd0, busy}, 32'd0);
    mf_req = 1'b1;
    mf_sel = 1'b1;
    #1;
    checkOutput("mflo_stall", {31'd0, stall}, 32'd0);
    checkOutput("mflo_data", mf_data, 32'h0000_1234);
    mf_req = 1'b0;
    issueOp(4'd4, 32'h0000_ABCD, 32'd0);
    checkOutput("mthi_hi", hi, 32'h0000_ABCD);

    // Flushed op in IDLE is ignored.
    applyStimulus(1'b1, 4'd0, 32'd3, 32'd3);
    flush = 1'b1;
    #1;
    checkOutput("flush_stall", {31'd0, stall}, 32'd0);
    tick(1);
    flush = 1'b0;
    applyStimulus(1'b0, 4'd0, 32'd0, 32'd0);
    checkOutput("flush_busy", {31'd0, busy}, 32'd0);
    tick(MUL_LAT + 1);
    checkOutput("flush_hi", hi, 32'h0000_ABCD);
    checkOutput("flush_lo", lo, 32'h0000_1234);

    // DIV in flight: a new op stalls unless flushed; reset discards it.
    issueOp(4'd2, 32'd1000, 32'd3);
    applyStimulus(1'b1, 4'd0, 32'd1, 32'd1);
    #1;
    checkOutput("busy_op_stall", {31'd0, stall}, 32'd1);
    flush = 1'b1;
    #1;
    checkOutput("busy_flush_stall", {31'd0, stall}, 32'd0);
    flush = 1'b0;
    applyStimulus(1'b0, 4'd0, 32'd0, 32'd0);
    tick(9);
    checkOutput("div_mid_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    checkOutput("midrst_hi", hi, 32'd0);
    checkOutput("midrst_lo", lo, 32'd0);
    checkOutput("midrst_busy", {31'd0, busy}, 32'd0);
    tick(30);
    checkOutput("midrst_stays_idle", {31'd0, busy}, 32'd0);
    checkOutput("midrst_lo_later", lo, 32'd0);

    // Op and MFHI together in IDLE: op accepted, MF sees pre-op HI.
    issueOp(4'd4, 32'h0000_5555, 32'd0);
    applyStimulus(1'b1, 4'd1, 32'd5, 32'd6);
    mf_req = 1'b1;
    mf_sel = 1'b0;
    #1;
    checkOutput("simul_mf_data", mf_data, 32'h0000_5555);
    checkOutput("simul_stall", {31'd0, stall}, 32'd0);
    tick(1);
    applyStimulus(1'b0, 4'd0, 32'd0, 32'd0);
    mf_req = 1'b0;
    checkOutput("simul_busy", {31'd0, busy}, 32'd1);
    waitIdle(20);
    checkOutput("multu_5x6_lo", lo, 32'd30);
    checkOutput("multu_5x6_hi", hi, 32'd0);

    // MADDU 1*1 onto {0, 0xFFFFFFFF}.
    issueOp(4'd4, 32'd0, 32'd0);
    issueOp(4'd5, 32'hFFFF_FFFF, 32'd0);
`ifdef MULDIV_MADD_EN
    issueOp(4'd7, 32'd1, 32'd1);
    waitIdle(20);
    checkOutput("maddu_hi", hi, 32'd1);
    checkOutput("maddu_lo", lo, 32'd0);
`else
    issueOp(4'd7, 32'd1, 32'd1);
    checkOutput("maddu_nop_busy", {31'd0, busy}, 32'd0);
    tick(MUL_LAT + 1);
    checkOutput("maddu_nop_hi", hi, 32'd0);
    checkOutput("maddu_nop_lo", lo, 32'hFFFF_FFFF);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global time bound so a hung DUT still ends the run.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: observed no finish, expected finish before 100000 ns");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
